// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide Data_Memory port between the D-cache (port 0)
// and I-cache (port 1); one whole transaction per grant, with a sticky no-ack timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [LINE_W-1:0] r0_data_i,
  input  logic              r0_enable_i,
  input  logic              r0_write_i,
  output logic              r0_ack_o,
  output logic [LINE_W-1:0] r0_data_o,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [LINE_W-1:0] r1_data_i,
  input  logic              r1_enable_i,
  input  logic              r1_write_i,
  output logic              r1_ack_o,
  output logic [LINE_W-1:0] r1_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q;
  logic              last_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              mem_en_q;
  logic [1:0]        grant_q;
  logic [1:0]        ack_q;
  logic [LINE_W-1:0] r0_rdata_q;
  logic [LINE_W-1:0] r1_rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_q;
  logic              pick_d;

  // On a tie the port that did not finish last wins; otherwise whichever is asking.
  assign pick_d = (r0_enable_i && r1_enable_i) ? ~last_q : r1_enable_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      grant_q    <= 2'b00;
      ack_q      <= 2'b00;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (r0_enable_i || r1_enable_i) begin
            owner_q  <= pick_d;
            grant_q  <= pick_d ? 2'b10 : 2'b01;
            addr_q   <= pick_d ? r1_addr_i  : r0_addr_i;
            wdata_q  <= pick_d ? r1_data_i  : r0_data_i;
            write_q  <= pick_d ? r1_write_i : r0_write_i;
            mem_en_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          // An ack arriving on the last allowed cycle still wins over the timeout.
          if (mem_ack_i || (cnt_q == CNT_LAST)) begin
            ack_q <= owner_q ? 2'b10 : 2'b01;
            if (owner_q) r1_rdata_q <= mem_ack_i ? mem_data_i : '0;
            else         r0_rdata_q <= mem_ack_i ? mem_data_i : '0;
            if (!mem_ack_i) timeout_q <= 1'b1;
            mem_en_q <= 1'b0;
            grant_q  <= 2'b00;
            last_q   <= owner_q;
            cnt_q    <= '0;
            state_q  <= RELEASE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_data_o   = wdata_q;
  assign mem_write_o  = write_q;
  assign mem_enable_o = mem_en_q;
  assign grant_o      = grant_q;
  assign r0_ack_o     = ack_q[0];
  assign r1_ack_o     = ack_q[1];
  assign r0_data_o    = r0_rdata_q;
  assign r1_data_o    = r1_rdata_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts grants and acks,
// a separate monitor compares every memory-side and requester-side event against it.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [ADDR_W-1:0] r0_addr_i = '0, r1_addr_i = '0;
  logic [LINE_W-1:0] r0_data_i = '0, r1_data_i = '0;
  logic              r0_enable_i = 1'b0, r1_enable_i = 1'b0;
  logic              r0_write_i = 1'b0, r1_write_i = 1'b0;
  logic              r0_ack_o, r1_ack_o;
  logic [LINE_W-1:0] r0_data_o, r1_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o, mem_write_o;
  logic              mem_ack_i = 1'b0;
  logic [LINE_W-1:0] mem_data_i = '0;
  logic [1:0]        grant_o;
  logic              timeout_o;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .r0_addr_i(r0_addr_i), .r0_data_i(r0_data_i), .r0_enable_i(r0_enable_i),
    .r0_write_i(r0_write_i), .r0_ack_o(r0_ack_o), .r0_data_o(r0_data_o),
    .r1_addr_i(r1_addr_i), .r1_data_i(r1_data_i), .r1_enable_i(r1_enable_i),
    .r1_write_i(r1_write_i), .r1_ack_o(r1_ack_o), .r1_data_o(r1_data_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int owner;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic wr;
    longint cyc;
    longint end_cyc;
  } mem_rec_t;

  typedef struct {
    int port;
    logic [LINE_W-1:0] data;
    logic to;
    longint cyc;
  } ack_rec_t;

  mem_rec_t mem_q[$];
  ack_rec_t ack_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Reference model: requesters, memory and arbitration rules at transaction level.
  int phase = 0;          // 0 = arbiter free, 1 = transaction in flight, 2 = release gap
  int wait_n = 0;
  int owner = 0;
  int last = 1;
  longint cur_end = 0;
  int grants = 0;
  logic              en[2];
  logic [ADDR_W-1:0] a[2];
  logic [LINE_W-1:0] d[2];
  logic              w[2];
  bit                outst[2];
  int p_req = 0, p_drop = 0, p_mut = 0, p_odrop = 0, p_spur = 0;
  int lat_lo = 2, lat_hi = 4;
  bit noack = 0;
  bit use_fdata = 0;
  logic [LINE_W-1:0] fdata = '0;

  task automatic drive();
    r0_enable_i = en[0]; r0_addr_i = a[0]; r0_data_i = d[0]; r0_write_i = w[0];
    r1_enable_i = en[1]; r1_addr_i = a[1]; r1_data_i = d[1]; r1_write_i = w[1];
  endtask

  task automatic new_req(input int p);
    en[p] = 1'b1;
    a[p]  = $urandom();
    d[p]  = rand_line();
    w[p]  = 1'($urandom_range(1));
  endtask

  task automatic model_body();
    bit arb_ok;
    int released;
    int g;
    int lat;
    mem_rec_t m;
    ack_rec_t r;
    released = -1;
    arb_ok = (phase == 0);
    mem_ack_i = 1'b0;
    mem_data_i = rand_line();
    if (phase == 1) begin
      wait_n--;
      if (wait_n == 0) begin
        r.port = owner;
        r.cyc  = cur_end;
        if (noack) begin
          r.data = '0;
          r.to   = 1'b1;
        end else begin
          mem_ack_i  = 1'b1;
          mem_data_i = use_fdata ? fdata : rand_line();
          r.data     = mem_data_i;
          r.to       = 1'b0;
        end
        ack_q.push_back(r);
        last  = owner;
        phase = 2;
      end
    end else begin
      if (phase == 2) begin
        outst[owner] = 1'b0;
        en[owner]    = 1'b0;
        released     = owner;
        phase        = 0;
      end
      if (int'($urandom_range(99)) < p_spur) mem_ack_i = 1'b1;
    end
    for (int p = 0; p < 2; p++) begin
      if (p != released) begin
        if (outst[p]) begin
          if (en[p] && int'($urandom_range(99)) < p_odrop) en[p] = 1'b0;
        end else if (!en[p]) begin
          if (int'($urandom_range(99)) < p_req) new_req(p);
        end else if (int'($urandom_range(99)) < p_drop) begin
          en[p] = 1'b0;
        end else if (int'($urandom_range(99)) < p_mut) begin
          new_req(p);
        end
      end
    end
    if (arb_ok && (en[0] || en[1])) begin
      if (en[0] && en[1]) g = 1 - last;
      else g = en[1] ? 1 : 0;
      lat = noack ? TIMEOUT : int'($urandom_range(lat_hi, lat_lo));
      m.owner   = g;
      m.addr    = a[g];
      m.data    = d[g];
      m.wr      = w[g];
      m.cyc     = cyc + 1;
      m.end_cyc = cyc + 1 + lat;
      mem_q.push_back(m);
      outst[g] = 1'b1;
      owner    = g;
      phase    = 1;
      wait_n   = lat;
      cur_end  = m.end_cyc;
      grants++;
    end
    drive();
  endtask

  task automatic step();
    @(negedge clk);
    model_body();
  endtask

  task automatic do_reset(input bit clear_req);
    @(negedge clk);
    rst_i = 1'b1;
    mem_ack_i = 1'b0;
    check("stale_mem_txns", LINE_W'(mem_q.size()), LINE_W'(0));
    check("stale_acks", LINE_W'(ack_q.size()), LINE_W'(0));
    mem_q.delete();
    ack_q.delete();
    phase = 0;
    last = 1;
    outst[0] = 1'b0;
    outst[1] = 1'b0;
    if (clear_req) begin
      en[0] = 1'b0;
      en[1] = 1'b0;
    end
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    model_body();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((phase != 0 || outst[0] || outst[1] || en[0] || en[1]) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: model still busy after %0d cycles", n);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  bit                prev_en = 1'b0;
  bit                have_cur = 1'b0;
  mem_rec_t          cur;
  logic [LINE_W-1:0] last_d[2];
  bit                exp_to = 1'b0;

  initial begin
    ack_rec_t r;
    logic ackp;
    last_d[0] = '0;
    last_d[1] = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        check("rst_mem_enable", LINE_W'(mem_enable_o), LINE_W'(0));
        check("rst_grant", LINE_W'(grant_o), LINE_W'(0));
        check("rst_acks", LINE_W'({r1_ack_o, r0_ack_o}), LINE_W'(0));
        check("rst_timeout", LINE_W'(timeout_o), LINE_W'(0));
        check("rst_mem_addr", LINE_W'(mem_addr_o), LINE_W'(0));
        check("rst_mem_data", mem_data_o, '0);
        check("rst_mem_write", LINE_W'(mem_write_o), LINE_W'(0));
        check("rst_r0_data", r0_data_o, '0);
        check("rst_r1_data", r1_data_o, '0);
        prev_en = 1'b0;
        have_cur = 1'b0;
        exp_to = 1'b0;
        last_d[0] = '0;
        last_d[1] = '0;
      end else begin
        if (mem_enable_o && !prev_en) begin
          if (mem_q.size() == 0) begin
            check("mem_txn_expected", LINE_W'(mem_q.size()), LINE_W'(1));
          end else begin
            cur = mem_q.pop_front();
            have_cur = 1'b1;
            check("mem_enable_rise_cycle", LINE_W'(cyc), LINE_W'(cur.cyc));
          end
        end
        if (mem_enable_o && have_cur) begin
          check("mem_addr", LINE_W'(mem_addr_o), LINE_W'(cur.addr));
          check("mem_data", mem_data_o, cur.data);
          check("mem_write", LINE_W'(mem_write_o), LINE_W'(cur.wr));
          check("grant_owner", LINE_W'(grant_o), LINE_W'(cur.owner == 1 ? 2'b10 : 2'b01));
        end else if (!mem_enable_o) begin
          check("grant_idle", LINE_W'(grant_o), LINE_W'(0));
        end
        if (!mem_enable_o && prev_en && have_cur) begin
          check("mem_enable_drop_cycle", LINE_W'(cyc), LINE_W'(cur.end_cyc));
          have_cur = 1'b0;
        end
        prev_en = mem_enable_o;
        for (int p = 0; p < 2; p++) begin
          ackp = (p == 1) ? r1_ack_o : r0_ack_o;
          if (ackp) begin
            if (ack_q.size() == 0) begin
              check("ack_expected", LINE_W'(ack_q.size()), LINE_W'(1));
            end else begin
              r = ack_q.pop_front();
              check("ack_port", LINE_W'(p), LINE_W'(r.port));
              check("ack_cycle", LINE_W'(cyc), LINE_W'(r.cyc));
              last_d[r.port] = r.data;
              if (r.to) exp_to = 1'b1;
            end
          end
        end
        check("r0_data", r0_data_o, last_d[0]);
        check("r1_data", r1_data_o, last_d[1]);
        check("timeout_flag", LINE_W'(timeout_o), LINE_W'(exp_to));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int n;
    for (int p = 0; p < 2; p++) begin
      en[p] = 1'b0; a[p] = '0; d[p] = '0; w[p] = 1'b0; outst[p] = 1'b0;
    end
    drive();

    // Reset with both ports requesting; port 0 must win first.
    new_req(0);
    new_req(1);
    drive();
    lat_lo = 2; lat_hi = 4;
    do_reset(1'b0);
    wait_idle();

    // Single line fill from port 1.
    lat_lo = 10; lat_hi = 10;
    use_fdata = 1'b1;
    fdata = LINE_W'(5);
    en[1] = 1'b1; a[1] = 32'h0000_0400; d[1] = rand_line(); w[1] = 1'b0;
    step();
    wait_idle();
    use_fdata = 1'b0;

    // Continuous contention for four transactions.
    lat_lo = 1; lat_hi = 4;
    p_req = 100;
    new_req(0);
    new_req(1);
    g0 = grants;
    n = 0;
    while (grants < g0 + 4 && n < 200) begin
      step();
      n++;
    end
    p_req = 0;
    wait_idle();

    // Write-back from port 0 while port 1 keeps changing its inputs.
    lat_lo = 6; lat_hi = 6;
    en[0] = 1'b1; a[0] = 32'h0000_0020; d[0] = LINE_W'(32'hDEAD_BEEF); w[0] = 1'b1;
    step();
    repeat (8) begin
      if (!outst[1]) begin
        en[1] = 1'($urandom_range(1));
        a[1]  = $urandom();
        d[1]  = rand_line();
        w[1]  = 1'($urandom_range(1));
      end
      step();
    end
    if (!outst[1]) en[1] = 1'b0;
    wait_idle();

    // Ack on the very last allowed cycle, then a real timeout, then a sticky flag.
    lat_lo = TIMEOUT; lat_hi = TIMEOUT;
    new_req(0);
    step();
    wait_idle();
    noack = 1'b1;
    new_req(1);
    step();
    wait_idle();
    noack = 1'b0;
    lat_lo = 3; lat_hi = 3;
    new_req(0);
    step();
    wait_idle();
    repeat (5) step();
    do_reset(1'b1);

    // Reset during the third BUSY cycle aborts with no ack.
    lat_lo = 50; lat_hi = 50;
    new_req(0);
    step();
    step();
    step();
    do_reset(1'b1);
    repeat (4) step();
    lat_lo = 2; lat_hi = 2;
    new_req(1);
    step();
    wait_idle();

    // Randomized traffic with drops, input churn and stray acks.
    lat_lo = 1; lat_hi = 8;
    p_req = 35; p_drop = 5; p_mut = 10; p_odrop = 5; p_spur = 15;
    repeat (500) step();
    p_req = 0; p_drop = 100; p_mut = 0; p_odrop = 0; p_spur = 0;
    wait_idle();
    repeat (3) step();
    check("leftover_mem_txns", LINE_W'(mem_q.size()), LINE_W'(0));
    check("leftover_acks", LINE_W'(ack_q.size()), LINE_W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
